// File: rtl/accum_ctrl.sv
// accum_ctrl: sequences an external accumulator over n_pix output pixels,
// each the sum of n_term input terms, with backpressure on the output side.
//
// Handshakes: a transfer happens on a cycle where valid && ready are both 1.
// The producer holds valid (and its data) steady until that cycle. Ready may
// depend combinationally on valid. Input side: in_valid/in_ready ("fire").
// Output side: out_valid/out_ready.
module accum_ctrl #(
  parameter int CNTW = 10
) (
  input  logic            clk,
  input  logic            xrst,
  input  logic            start,
  input  logic [CNTW-1:0] n_term,
  input  logic [CNTW-1:0] n_pix,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            acc_reset,
  output logic            acc_out_en,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CNTW-1:0] term_idx,
  output logic [CNTW-1:0] pix_idx,
  output logic            busy,
  output logic            done,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACC   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state, state_nx;
  logic [CNTW-1:0] nt_q;
  logic [CNTW-1:0] np_q;
  logic            last_term;
  logic            last_pix;
  logic            fire;
  logic            out_hs;
  logic            job_go;

  // Per-term decode: where we are inside the current pixel and job.
  always_comb begin
    last_term = (term_idx == nt_q - 1'b1);
    last_pix  = (pix_idx == np_q - 1'b1);
    job_go    = (state == S_IDLE) && start && (n_pix != '0);
    // Never accept the last term of a pixel while the previous pixel is
    // still waiting downstream: its load would overwrite pixel_out.
    in_ready  = (state == S_ACC) && !(last_term && out_valid && !out_ready);
    fire      = in_valid && in_ready;
    acc_reset = (state == S_ACC) && (term_idx == '0);
    acc_out_en = fire && last_term;
    out_hs    = out_valid && out_ready && ((state == S_ACC) || (state == S_DRAIN));
  end

  // State register.
  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // Next-state and status outputs.
  always_comb begin
    state_nx  = state;
    busy      = 1'b0;
    done      = 1'b0;
    dbg_state = state;
    case (state)
      S_IDLE: begin
        if (start) state_nx = (n_pix != '0) ? S_ACC : S_DONE;
      end
      S_ACC: begin
        busy = 1'b1;
        if (acc_out_en && last_pix) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (out_hs) state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Job counts and term/pixel indices; n_term of zero behaves as one term.
  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      nt_q     <= '0;
      np_q     <= '0;
      term_idx <= '0;
      pix_idx  <= '0;
    end else if (job_go) begin
      nt_q     <= (n_term == '0) ? CNTW'(1) : n_term;
      np_q     <= n_pix;
      term_idx <= '0;
      pix_idx  <= '0;
    end else if (fire) begin
      if (last_term) begin
        term_idx <= '0;
        pix_idx  <= pix_idx + 1'b1;
      end else begin
        term_idx <= term_idx + 1'b1;
      end
    end
  end

  // Output-valid flag: a new load wins over a same-cycle handshake.
  always_ff @(posedge clk or posedge xrst) begin
    if (xrst)            out_valid <= 1'b0;
    else if (acc_out_en) out_valid <= 1'b1;
    else if (out_hs)     out_valid <= 1'b0;
  end

endmodule
